conv_monitor: RTL and testbench



---
 rtl/conv_mon_pkg.sv | 25 ++
 rtl/conv_chan.sv | 47 ++++
 rtl/conv_monitor.sv | 132 +++++++++++++
 tb/tb_conv_monitor.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mon_pkg.sv
// Shared types and helpers for the convergence monitor: FSM states, mode
// encoding and a width-safe absolute-difference function.
package conv_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic MODE_ANY = 1'b0;
  localparam logic MODE_ALL = 1'b1;

  // Widest channel value the helper supports; channels sign-extend into it.
  localparam int ABS_W = 32;

  // One extra bit of headroom keeps |a - b| exact even at opposite extremes.
  function automatic logic [ABS_W:0] abs_diff(input logic signed [ABS_W-1:0] a,
                                              input logic signed [ABS_W-1:0] b);
    logic signed [ABS_W:0] d;
    d = (ABS_W+1)'(a) - (ABS_W+1)'(b);
    return d[ABS_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/conv_chan.sv
// One monitored channel: in-margin test, consecutive-hold counter and a
// sticky converged flag. Supports W up to conv_mon_pkg::ABS_W.
module conv_chan
  import conv_mon_pkg::*;
#(
  parameter int W      = 16,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [W-1:0]      actual,
  input  logic [W-1:0]      target,
  input  logic [W-1:0]      margin,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              conv
);

  logic [ABS_W:0]    diff;
  logic              in_margin;
  logic [HOLD_W-1:0] hold_cnt;

  assign diff      = abs_diff(ABS_W'($signed(actual)), ABS_W'($signed(target)));
  // Strict compare, so a zero margin can never be met.
  assign in_margin = diff < (ABS_W+1)'(margin);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      conv     <= 1'b0;
    end else if (clr) begin
      hold_cnt <= '0;
      conv     <= 1'b0;
    end else if (en) begin
      if (in_margin) begin
        if (hold_cnt == hold_cycles) conv <= 1'b1;
        if (hold_cnt != '1) hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/conv_monitor.sv
// N-channel convergence monitor: latches a check configuration on start, then
// reports pass (all/any enabled channels converged) or timeout.
module conv_monitor
  import conv_mon_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int W      = 16,
  parameter int TMR_W  = 27,
  parameter int HOLD_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NCH-1:0]     ch_en,
  input  logic               mode_all,
  input  logic [W-1:0]       margin,
  input  logic [TMR_W-1:0]   timeout_cycles,
  input  logic [HOLD_W-1:0]  hold_cycles,
  input  logic [NCH*W-1:0]   actual,
  input  logic [NCH*W-1:0]   target,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timed_out,
  output logic [NCH-1:0]     conv_mask,
  output logic [TMR_W-1:0]   cycles_elapsed
);

  state_t             state;
  logic [NCH-1:0]     en_q;
  logic               mode_q;
  logic [W-1:0]       margin_q;
  logic [TMR_W-1:0]   timeout_q;
  logic [HOLD_W-1:0]  hold_q;

  logic               clr;
  logic               eval;
  logic [NCH-1:0]     conv_en;
  logic               complete;
  logic               timeout_hit;

  assign clr     = (state == IDLE) && start;
  // Channels freeze on the abort edge so conv_mask shows what was reached.
  assign eval    = (state == RUN) && !abort;
  assign conv_en = conv_mask & en_q;

  // An empty enable set completes vacuously in either mode.
  assign complete    = (en_q == '0) ||
                       ((mode_q == MODE_ALL) ? (conv_en == en_q) : (conv_en != '0));
  assign timeout_hit = (timeout_q != '0) && (cycles_elapsed == timeout_q - TMR_W'(1));

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    conv_chan #(
      .W      (W),
      .HOLD_W (HOLD_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .en          (eval && en_q[i]),
      .actual      (actual[i*W +: W]),
      .target      (target[i*W +: W]),
      .margin      (margin_q),
      .hold_cycles (hold_q),
      .conv        (conv_mask[i])
    );
  end

  // NOTE: the latched configuration is reset too, so a check can never start
  // from X values left behind by power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timed_out      <= 1'b0;
      cycles_elapsed <= '0;
      en_q           <= '0;
      mode_q         <= MODE_ANY;
      margin_q       <= '0;
      timeout_q      <= '0;
      hold_q         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            en_q           <= ch_en;
            mode_q         <= mode_all;
            margin_q       <= margin;
            timeout_q      <= timeout_cycles;
            hold_q         <= hold_cycles;
            cycles_elapsed <= '0;
            pass           <= 1'b0;
            timed_out      <= 1'b0;
            busy           <= 1'b1;
            state          <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            state     <= IDLE;
          end else if (complete) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
            state <= DONE;
          end else if (timeout_hit) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
            state     <= DONE;
          end else if (cycles_elapsed != '1) begin
            cycles_elapsed <= cycles_elapsed + TMR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_monitor.sv
// Self-checking bench for conv_monitor: directed scenarios plus randomized
// runs, all predicted by a window-based reference model over stored stimulus.
module tb_conv_monitor;
  import conv_mon_pkg::*;

  localparam int NCH    = 3;
  localparam int W      = 16;
  localparam int TMR_W  = 27;
  localparam int HOLD_W = 16;
  localparam int L      = 1200;
  localparam int NEVER  = 1_000_000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [NCH-1:0]     ch_en = '0;
  logic               mode_all = 1'b0;
  logic [W-1:0]       margin = '0;
  logic [TMR_W-1:0]   timeout_cycles = '0;
  logic [HOLD_W-1:0]  hold_cycles = '0;
  logic [NCH*W-1:0]   actual = '0;
  logic [NCH*W-1:0]   target = '0;
  logic               busy;
  logic               done;
  logic               pass;
  logic               timed_out;
  logic [NCH-1:0]     conv_mask;
  logic [TMR_W-1:0]   cycles_elapsed;

  int total = 0;
  int bad   = 0;
  int act_v [NCH][L];
  int tgt_v [NCH][L];

  conv_monitor #(
    .NCH(NCH), .W(W), .TMR_W(TMR_W), .HOLD_W(HOLD_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .ch_en          (ch_en),
    .mode_all       (mode_all),
    .margin         (margin),
    .timeout_cycles (timeout_cycles),
    .hold_cycles    (hold_cycles),
    .actual         (actual),
    .target         (target),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timed_out      (timed_out),
    .conv_mask      (conv_mask),
    .cycles_elapsed (cycles_elapsed)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      $error("comparison %s differs", tag);
    end
  endtask

  task automatic drive(input int k);
    for (int i = 0; i < NCH; i++) begin
      actual[i*W +: W] = W'(act_v[i][k]);
      target[i*W +: W] = W'(tgt_v[i][k]);
    end
  endtask

  task automatic fill_const(input int ch, input int a, input int t);
    for (int k = 0; k < L; k++) begin
      act_v[ch][k] = a;
      tgt_v[ch][k] = t;
    end
  endtask

  // Channel converges at the first sample index closing a window of hold+1
  // consecutive in-margin samples; the result appears one edge after the
  // deciding latch, and timeout fires at index timeout-1 unless completion
  // lands there too.
  function automatic void predict(input logic [NCH-1:0] en, input logic all_m,
                                  input int mg, input int hold, input int tmo,
                                  output int fin, output logic p_exp,
                                  output logic [NCH-1:0] m_exp);
    int latch [NCH];
    int cc;
    for (int i = 0; i < NCH; i++) begin
      latch[i] = NEVER;
      for (int k = hold; k < L; k++) begin
        bit ok = 1'b1;
        for (int j = k - hold; j <= k; j++) begin
          int d = act_v[i][j] - tgt_v[i][j];
          if (d < 0) d = -d;
          if (!(d < mg)) ok = 1'b0;
        end
        if (ok) begin
          latch[i] = k;
          break;
        end
      end
    end
    if (en == '0) cc = 0;
    else begin
      cc = all_m ? -1 : NEVER;
      for (int i = 0; i < NCH; i++) begin
        if (en[i] && all_m && latch[i] > cc) cc = latch[i];
        if (en[i] && !all_m && latch[i] < cc) cc = latch[i];
      end
      cc = cc + 1;
    end
    if (tmo != 0 && cc > tmo - 1) begin
      fin   = tmo - 1;
      p_exp = 1'b0;
    end else begin
      fin   = cc;
      p_exp = 1'b1;
    end
    for (int i = 0; i < NCH; i++) m_exp[i] = en[i] && (latch[i] <= fin);
  endfunction

  task automatic run_check(input string tag, input logic [NCH-1:0] en, input logic all_m,
                           input int mg, input int hold, input int tmo);
    int fin;
    int seen;
    logic p_exp;
    logic [NCH-1:0] m_exp;
    predict(en, all_m, mg, hold, tmo, fin, p_exp, m_exp);
    ch_en          = en;
    mode_all       = all_m;
    margin         = W'(mg);
    hold_cycles    = HOLD_W'(hold);
    timeout_cycles = TMR_W'(tmo);
    start = 1'b1;
    drive(0);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'(1));
    seen = -1;
    for (int k = 0; k < L; k++) begin
      drive(k);
      @(posedge clk); #1;
      if (done) begin
        seen = k;
        break;
      end
    end
    check({tag, ".done_at"}, 64'(seen), 64'(fin));
    check({tag, ".pass"}, 64'(pass), 64'(p_exp));
    check({tag, ".timed_out"}, 64'(timed_out), 64'(!p_exp));
    check({tag, ".conv_mask"}, 64'(conv_mask), 64'(m_exp));
    check({tag, ".elapsed"}, 64'(cycles_elapsed), 64'(fin));
    check({tag, ".busy_off"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(done), 64'(0));
    check({tag, ".pass_held"}, 64'(pass), 64'(p_exp));
  endtask

  initial begin
    int v;
    int done_seen;

    // Reset state
    #12;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.pass", 64'(pass), 64'(0));
    check("rst.timed_out", 64'(timed_out), 64'(0));
    check("rst.conv_mask", 64'(conv_mask), 64'(0));
    check("rst.elapsed", 64'(cycles_elapsed), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Staggered ramps toward zero, all must converge
    for (int i = 0; i < NCH; i++)
      for (int k = 0; k < L; k++) begin
        v = (k < 20 * i) ? 100 : 100 - (k - 20 * i);
        act_v[i][k] = (v < 0) ? 0 : v;
        tgt_v[i][k] = 0;
      end
    run_check("ramp", 3'b111, MODE_ALL, 10, 0, 1000);

    // Channel 1 stuck out of margin, timeout wins
    fill_const(1, 50, 0);
    run_check("stuck", 3'b111, MODE_ALL, 10, 0, 500);

    // Any mode with hold: 3 in, 1 out, then in
    for (int k = 0; k < L; k++) begin
      act_v[0][k] = (k == 3) ? 100 : 0;
      tgt_v[0][k] = 0;
    end
    fill_const(1, 1000, 0);
    fill_const(2, 1000, 0);
    run_check("hold", 3'b111, MODE_ANY, 10, 4, 1000);

    // Opposite extremes must not wrap into the margin
    for (int k = 0; k < L; k++) begin
      act_v[0][k] = (k < 20) ? -32768 : 32760;
      tgt_v[0][k] = 32767;
    end
    run_check("ovf", 3'b001, MODE_ALL, 65535, 0, 0);

    // Vacuous enable set, with and without a one-cycle timeout
    run_check("noen", 3'b000, MODE_ALL, 10, 0, 1000);
    run_check("noen_t1", 3'b000, MODE_ANY, 10, 0, 1);

    // Completion and timeout on the same cycle, and one cycle early
    fill_const(0, 5, 0);
    fill_const(1, -3, 0);
    fill_const(2, 0, 2);
    run_check("tie", 3'b111, MODE_ALL, 10, 5, 7);
    run_check("tie_early", 3'b111, MODE_ALL, 10, 5, 6);
    run_check("zero_margin", 3'b111, MODE_ALL, 0, 0, 40);

    // Abort, with a start pulse in RUN that must be ignored
    fill_const(0, 0, 0);
    fill_const(1, 500, 0);
    fill_const(2, 500, 0);
    ch_en = 3'b111; mode_all = MODE_ALL; margin = 16'd10;
    hold_cycles = '0; timeout_cycles = '0;
    start = 1'b1;
    drive(0);
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 5);
      if (k == 5) timeout_cycles = TMR_W'(3);
      abort = (k == 9);
      drive(k);
      @(posedge clk); #1;
      if (done) done_seen = 1;
      if (k == 5) begin
        check("abort.restart_ignored", 64'(cycles_elapsed), 64'(6));
        check("abort.busy_run", 64'(busy), 64'(1));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.pass", 64'(pass), 64'(0));
    check("abort.timed_out", 64'(timed_out), 64'(0));
    check("abort.conv_mask", 64'(conv_mask), 64'(3'b001));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    check("abort.no_done", 64'(done_seen), 64'(0));

    // Randomized runs against the reference model
    for (int r = 0; r < 16; r++) begin
      logic [NCH-1:0] en_r;
      int mg, hold, tmo;
      en_r = NCH'($urandom_range(0, 7));
      mg   = int'($urandom_range(1, 40));
      hold = int'($urandom_range(0, 5));
      tmo  = int'($urandom_range(30, 400));
      for (int i = 0; i < NCH; i++) begin
        int base = int'($urandom_range(0, 2000)) - 1000;
        int pin  = int'($urandom_range(40, 97));
        for (int k = 0; k < L; k++) begin
          int off;
          tgt_v[i][k] = base + k / 16;
          if (int'($urandom_range(0, 99)) < pin)
            off = int'($urandom_range(0, 2 * mg - 2)) - (mg - 1);
          else begin
            off = mg + int'($urandom_range(0, 200));
            if ($urandom_range(0, 1) == 1) off = -off;
          end
          act_v[i][k] = tgt_v[i][k] + off;
        end
      end
      run_check($sformatf("rnd%0d", r), en_r, 1'($urandom_range(0, 1)), mg, hold, tmo);
    end

    // Asynchronous reset in the middle of a run
    fill_const(0, 0, 0);
    fill_const(1, 500, 0);
    fill_const(2, 500, 0);
    ch_en = 3'b111; mode_all = MODE_ALL; margin = 16'd10;
    hold_cycles = '0; timeout_cycles = '0;
    start = 1'b1;
    drive(0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(k);
      @(posedge clk); #1;
    end
    check("mid.conv_mask_pre", 64'(conv_mask), 64'(3'b001));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid.busy", 64'(busy), 64'(0));
    check("mid.done", 64'(done), 64'(0));
    check("mid.pass", 64'(pass), 64'(0));
    check("mid.timed_out", 64'(timed_out), 64'(0));
    check("mid.conv_mask", 64'(conv_mask), 64'(0));
    check("mid.elapsed", 64'(cycles_elapsed), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid.idle_after", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
